// File: rtl/dco_pkg.sv
// rtl/dco_pkg.sv - shared state type and default parameters for the dco_idn oscillator
package dco_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dco_state_e;

    localparam int DCO_DIV_N_DEF  = 8;
    localparam int DCO_CORR_W_DEF = 4;

endpackage

// File: rtl/dco_corr_acc.sv
// rtl/dco_corr_acc.sv - saturating signed pending-correction counter with sticky saturation flag
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   add, sub               one-cycle correction requests (+1 / -1)
//   consume_up, consume_dn a period start consumed a positive / negative correction
//   clr_sat                clears the sticky saturation flag
//   pend                   signed pending correction count (two's complement)
//   sat                    sticky flag, set when an update hits either bound
module dco_corr_acc
    import dco_pkg::*;
#(
    parameter int CORR_W = DCO_CORR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add,
    input  logic              sub,
    input  logic              consume_up,
    input  logic              consume_dn,
    input  logic              clr_sat,
    output logic [CORR_W-1:0] pend,
    output logic              sat
);

    // Symmetric bounds: the most negative code is never used.
    localparam logic signed [CORR_W+1:0] POS_LIM = (CORR_W+2)'(2**(CORR_W-1) - 1);
    localparam logic signed [CORR_W+1:0] NEG_LIM = -POS_LIM;

    logic [CORR_W-1:0]        pend_q, pend_d;
    logic                     sat_q, sat_d;
    logic signed [CORR_W+1:0] ext, inc, dec, sum;
    logic                     over_hi, over_lo;

    always_comb begin
        // Two guard bits so the sum of up to +/-2 never wraps before the bound test.
        ext = {{2{pend_q[CORR_W-1]}}, pend_q};
        // Two-bit sum of two single-bit terms: {a&b, a^b} == a + b.
        inc = {{CORR_W{1'b0}}, add & consume_dn, add ^ consume_dn};
        dec = {{CORR_W{1'b0}}, sub & consume_up, sub ^ consume_up};
        sum = ext + inc - dec;

        over_hi = (sum > POS_LIM);
        over_lo = (sum < NEG_LIM);

        pend_d = sum[CORR_W-1:0];
        if (over_hi) begin
            pend_d = POS_LIM[CORR_W-1:0];
        end else if (over_lo) begin
            pend_d = NEG_LIM[CORR_W-1:0];
        end

        // A fresh saturation event wins over a simultaneous clear.
        sat_d = (sat_q & ~clr_sat) | over_hi | over_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            sat_q  <= sat_d;
        end
    end

    assign pend = pend_q;
    assign sat  = sat_q;

endmodule

// File: rtl/dco_idn.sv
// rtl/dco_idn.sv - digitally controlled oscillator with +/-1 clk period corrections
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             run enable (IDLE <-> RUN)
//   add, sub       one-cycle requests to shorten / lengthen one future period by one clk
//   clr_sat        clears the sticky saturation flag
//   dco_clk        registered oscillator output, high for the first DIV_N/2 cycles of a period
//   dco_tick       registered pulse in the first cycle of each period
//   pend           signed pending correction count
//   sat            sticky saturation flag
module dco_idn
    import dco_pkg::*;
#(
    parameter int DIV_N  = DCO_DIV_N_DEF,
    parameter int CORR_W = DCO_CORR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              add,
    input  logic              sub,
    input  logic              clr_sat,
    output logic              dco_clk,
    output logic              dco_tick,
    output logic [CORR_W-1:0] pend,
    output logic              sat
);

    localparam int             CW        = $clog2(DIV_N + 2);
    localparam logic [CW-1:0]  HALF      = CW'(DIV_N / 2);
    localparam logic [CW-1:0]  PER_NOM   = CW'(DIV_N);
    localparam logic [CW-1:0]  PER_SHORT = CW'(DIV_N - 1);
    localparam logic [CW-1:0]  PER_LONG  = CW'(DIV_N + 1);
    localparam logic [CW-1:0]  ONE       = CW'(1);

    dco_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     per_q, per_d;
    logic              dco_clk_q, dco_clk_d;
    logic              dco_tick_q, dco_tick_d;
    logic              start;
    logic              pend_pos, pend_neg;
    logic              consume_up, consume_dn;

    assign pend_pos = ~pend[CORR_W-1] & (|pend);
    assign pend_neg = pend[CORR_W-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    // Partial period is dropped; its correction (if any) was
                    // already taken at its start, nothing further is consumed.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == per_q - ONE) begin
                    cnt_d = '0;
                    start = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        consume_up = start & pend_pos;
        consume_dn = start & pend_neg;

        if (start) begin
            if (pend_pos) begin
                per_d = PER_SHORT;
            end else if (pend_neg) begin
                per_d = PER_LONG;
            end else begin
                per_d = PER_NOM;
            end
        end

        // Outputs are registered from next-state so they line up with cnt_q.
        dco_clk_d  = (state_d == RUN) && (cnt_d < HALF);
        dco_tick_d = (state_d == RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            per_q      <= PER_NOM;
            dco_clk_q  <= 1'b0;
            dco_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_q      <= per_d;
            dco_clk_q  <= dco_clk_d;
            dco_tick_q <= dco_tick_d;
        end
    end

    dco_corr_acc #(
        .CORR_W(CORR_W)
    ) u_corr_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .add       (add),
        .sub       (sub),
        .consume_up(consume_up),
        .consume_dn(consume_dn),
        .clr_sat   (clr_sat),
        .pend      (pend),
        .sat       (sat)
    );

    assign dco_clk  = dco_clk_q;
    assign dco_tick = dco_tick_q;

endmodule

// File: tb/tb_dco_idn.sv
// tb/tb_dco_idn.sv - scoreboard testbench for dco_idn (DIV_N=8, CORR_W=4)
module tb_dco_idn;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       add;
    logic       sub;
    logic       clr_sat;
    logic       dco_clk;
    logic       dco_tick;
    logic [3:0] pend;
    logic       sat;

    dco_idn #(
        .DIV_N (8),
        .CORR_W(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .add     (add),
        .sub     (sub),
        .clr_sat (clr_sat),
        .dco_clk (dco_clk),
        .dco_tick(dco_tick),
        .pend    (pend),
        .sat     (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int high;
        int pend;
    } period_t;

    typedef struct {
        string nm;
        int    act;
        int    req;
    } obs_t;

    period_t exp_q[$];
    obs_t    obs_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int abandon_cnt  = 0;
    int abandon_seen = 0;
    bit have_prev    = 0;
    int cur_len      = 0;
    int cur_high     = 0;
    int exp_len      = 0;
    int exp_high     = 0;
    period_t e;
    obs_t    o;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: drains sampled direct observations and scores each period at dco_tick.
    always @(negedge clk) begin
        if (abandon_cnt != abandon_seen) begin
            abandon_seen = abandon_cnt;
            have_prev    = 0;
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            chk(o.nm, o.act, o.req);
        end
        if (dco_tick) begin
            if (have_prev) begin
                chk("period_len", cur_len, exp_len);
                chk("period_high", cur_high, exp_high);
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("tick_pend", int'(pend), e.pend);
                exp_len  = e.len;
                exp_high = e.high;
            end
            have_prev = 1;
            cur_len   = 1;
            cur_high  = dco_clk ? 1 : 0;
        end else if (have_prev) begin
            cur_len++;
            if (dco_clk) cur_high++;
        end
    end

    task automatic obs(input string nm, input int act, input int req);
        obs_t t;
        t.nm  = nm;
        t.act = act;
        t.req = req;
        obs_q.push_back(t);
    endtask

    task automatic push_period(input int len, input int high, input int pv);
        period_t p;
        p.len  = len;
        p.high = high;
        p.pend = pv;
        exp_q.push_back(p);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_tick(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dco_tick && n < 20);
        obs(nm, int'(dco_tick), 1);
    endtask

    task automatic pulse_add();
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_sub();
        sub = 1'b1;
        cyc(1);
        sub = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        add     = 1'b0;
        sub     = 1'b0;
        clr_sat = 1'b0;
        cyc(3);
        obs("rst_dco_clk", int'(dco_clk), 0);
        obs("rst_dco_tick", int'(dco_tick), 0);
        obs("rst_pend", int'(pend), 0);
        obs("rst_sat", int'(sat), 0);
        rst_n = 1'b1;

        // Free run, single add, single sub, add+sub cancel, add on a period start.
        push_period(8, 4, 0);
        push_period(8, 4, 0);
        push_period(8, 4, 0);
        push_period(7, 4, 0);
        push_period(8, 4, 0);
        push_period(9, 4, 0);
        push_period(8, 4, 0);
        push_period(8, 4, 0);
        push_period(7, 4, 1);
        push_period(7, 4, 0);
        push_period(8, 4, 0);
        en = 1'b1;
        sync_tick("tick_p1");
        sync_tick("tick_p2");
        sync_tick("tick_p3");
        cyc(2);
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        obs("pend_after_add", int'(pend), 1);
        sync_tick("tick_p4");
        sync_tick("tick_p5");
        cyc(3);
        sub = 1'b1;
        cyc(1);
        sub = 1'b0;
        obs("pend_after_sub", int'(pend), 15);
        sync_tick("tick_p6");
        sync_tick("tick_p7");
        cyc(1);
        add = 1'b1;
        sub = 1'b1;
        cyc(1);
        add = 1'b0;
        sub = 1'b0;
        obs("pend_add_sub_cancel", int'(pend), 0);
        sync_tick("tick_p8");
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        obs("pend_p8_add", int'(pend), 1);
        cyc(6);
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        obs("p9_start_tick", int'(dco_tick), 1);
        obs("p9_start_pend", int'(pend), 1);
        sync_tick("tick_p10");
        sync_tick("tick_p11");

        // en falls mid-period with a pending correction.
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        cyc(1);
        obs("p11_high_before_stop", int'(dco_clk), 1);
        en = 1'b0;
        abandon_cnt++;
        cyc(1);
        obs("stop_dco_clk", int'(dco_clk), 0);
        obs("stop_dco_tick", int'(dco_tick), 0);
        obs("stop_pend_kept", int'(pend), 1);
        cyc(8);
        obs("idle_pend_kept", int'(pend), 1);
        obs("idle_dco_clk", int'(dco_clk), 0);

        // Reset mid-period at cnt=5 with pend=3.
        pulse_add();
        pulse_add();
        obs("idle_pend_3", int'(pend), 3);
        push_period(7, 4, 2);
        en = 1'b1;
        cyc(1);
        add = 1'b1;
        cyc(1);
        add = 1'b0;
        cyc(4);
        obs("cnt5_pend", int'(pend), 3);
        rst_n = 1'b0;
        abandon_cnt++;
        cyc(1);
        obs("midrst_dco_clk", int'(dco_clk), 0);
        obs("midrst_dco_tick", int'(dco_tick), 0);
        obs("midrst_pend", int'(pend), 0);
        obs("midrst_sat", int'(sat), 0);
        rst_n = 1'b1;
        en    = 1'b0;
        cyc(2);
        obs("postrst_idle_tick", int'(dco_tick), 0);
        obs("postrst_idle_clk", int'(dco_clk), 0);

        // Positive saturation in IDLE, clear, clear racing a new saturation.
        repeat (7) pulse_add();
        obs("sat7_pend", int'(pend), 7);
        obs("sat7_flag", int'(sat), 0);
        pulse_add();
        obs("sat8_pend", int'(pend), 7);
        obs("sat8_flag", int'(sat), 1);
        pulse_add();
        obs("sat9_pend", int'(pend), 7);
        obs("sat9_flag", int'(sat), 1);
        clr_sat = 1'b1;
        cyc(1);
        clr_sat = 1'b0;
        obs("clr_sat_flag", int'(sat), 0);
        add     = 1'b1;
        clr_sat = 1'b1;
        cyc(1);
        add     = 1'b0;
        clr_sat = 1'b0;
        obs("clr_vs_sat_flag", int'(sat), 1);
        obs("clr_vs_sat_pend", int'(pend), 7);
        clr_sat = 1'b1;
        cyc(1);
        clr_sat = 1'b0;
        obs("clr2_sat_flag", int'(sat), 0);

        // Drain seven corrections: seven 7-cycle periods, then nominal.
        for (int i = 0; i < 7; i++) push_period(7, 4, 6 - i);
        for (int i = 0; i < 3; i++) push_period(8, 4, 0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) sync_tick("tick_drain");
        en = 1'b0;
        abandon_cnt++;
        cyc(2);

        // Negative saturation bound.
        repeat (8) pulse_sub();
        obs("negsat_pend", int'(pend), 9);
        obs("negsat_flag", int'(sat), 1);
        clr_sat = 1'b1;
        cyc(1);
        clr_sat = 1'b0;
        obs("negsat_clr", int'(sat), 0);

        obs("exp_q_drained", exp_q.size(), 0);
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
